// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-outstanding imem request/response, instruction register, retire counter.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned branch targets trap instead of being truncated to a word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7_bit5,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instret,
  output logic        fetch_trap
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
`ifdef FETCH_MISALIGN_TRAP_EN
    TRAP  = 3'd4,
`endif
    ISSUE = 3'd3
  } state_t;

  state_t             state, state_nxt;
  logic signed [31:0] pc_s, imm_s;
  logic        [31:0] br_target, pc_nxt;
  logic               retire, trap_hit;

  assign pc_s        = $signed(pc);
  assign imm_s       = $signed(imm_ext);
  assign br_target   = $unsigned(pc_s + imm_s);
  assign pc_plus4    = pc + 32'd4;
  assign pc_nxt      = pc_src ? (br_target & ~32'h3) : pc_plus4;
  assign retire      = (state == ISSUE) && exec_done;

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7_bit5 = instr[30];

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap_hit = retire && pc_src && (br_target[1:0] != 2'b00);
`else
  assign trap_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (imem_rvalid) state_nxt = ISSUE;
`ifdef FETCH_MISALIGN_TRAP_EN
      ISSUE:   if (exec_done) state_nxt = trap_hit ? TRAP : REQ;
      TRAP:    state_nxt = TRAP;
`else
      ISSUE:   if (exec_done) state_nxt = REQ;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      instret     <= '0;
    end else begin
      state <= state_nxt;
      if ((state == WAIT) && imem_rvalid) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      // A trapping branch still retires but leaves pc on the offending instruction
      if (retire) begin
        instr_valid <= 1'b0;
        instret     <= instret + 32'd1;
        if (!trap_hit) pc <= pc_nxt;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_trap <= 1'b0;
    else if (trap_hit) fetch_trap <= 1'b1;
  end
`else
  assign fetch_trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, randomized fetch/retire traffic against a spec-level model,
// plus hand-written trap, wrap and asynchronous-reset sequences.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_rvalid, instr_valid, exec_done, pc_src, funct7_bit5, fetch_trap;
  logic [31:0] imem_addr, imem_rdata, instr, imm_ext, pc, pc_plus4, instret;
  logic [6:0]  op;
  logic [2:0]  funct3;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .op(op),
    .funct3(funct3), .funct7_bit5(funct7_bit5), .instr_valid(instr_valid),
    .exec_done(exec_done), .pc_src(pc_src), .imm_ext(imm_ext), .pc(pc),
    .pc_plus4(pc_plus4), .instret(instret), .fetch_trap(fetch_trap)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0, errors = 0;

  // reference model state
  logic [31:0] m_pc, m_instret;
  logic        m_trap;
  int          last_issue, last_wait;
  bit          have_last;

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic [6:0]  op;
    int          ewait;
    bit          src;
    logic [31:0] imm;
    bit          spur;
    bit          wrap;
    logic [31:0] next_pc;
    logic [31:0] instret;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input bit src, input logic [31:0] imm);
    return src ? ((p + imm) & 32'hFFFF_FFFC) : (p + 32'd4);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_instret = 0; m_trap = 0; have_last = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},     imem_req, 0);
    check({tag, "_pc"},      pc, RESET_PC);
    check({tag, "_instr"},   instr, NOP);
    check({tag, "_valid"},   instr_valid, 0);
    check({tag, "_instret"}, instret, 0);
    check({tag, "_trap"},    fetch_trap, 0);
    check({tag, "_op"},      op, 7'h13);
  endtask

  // One full fetch/execute transaction; expects to start at or before the REQ cycle.
  task automatic run_instr(input int lat, input logic [31:0] data, input logic [6:0] exp_op,
                           input int ewait, input bit src, input logic [31:0] imm,
                           input bit spur, input bit wrap);
    int n;
    int issue_cyc;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    check("req_seen", imem_req, 1);
    check("imem_addr", imem_addr, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    imem_rvalid = spur; imem_rdata = ~data;
    exec_done = 1'($urandom); pc_src = 1'b1; imm_ext = $urandom;
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      check("req_low_wait", imem_req, 0);
      exec_done = 1'($urandom);
      if (i == lat) begin imem_rvalid = 1'b1; imem_rdata = data; end
      @(negedge clk);
      imem_rvalid = 1'b0; imem_rdata = $urandom; exec_done = 1'b0;
    end
    issue_cyc = cycle;
    check("issue_valid", instr_valid, 1);
    check("issue_instr", instr, data);
    check("issue_op", op, exp_op);
    check("issue_funct3", funct3, data[14:12]);
    check("issue_f7b5", funct7_bit5, data[30]);
    check("issue_instret", instret, m_instret);
    if (have_last) check("issue_gap", issue_cyc - last_issue, last_wait + lat + 2);
    if (wrap) begin
      force dut.instret = 32'hFFFF_FFFF;
      #1;
      release dut.instret;
      m_instret = 32'hFFFF_FFFF;
    end
    for (int j = 0; j < ewait; j++) begin
      exec_done = 1'b0; pc_src = 1'b1; imm_ext = $urandom;
      imem_rvalid = spur; imem_rdata = ~data;
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("hold_instr", instr, data);
      check("hold_valid", instr_valid, 1);
      check("hold_pc", pc, m_pc);
      check("hold_req", imem_req, 0);
    end
    exec_done = 1'b1; pc_src = src; imm_ext = imm;
    @(negedge clk);
    exec_done = 1'b0; pc_src = 1'($urandom); imm_ext = $urandom;
    m_instret = m_instret + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (src && ((m_pc + imm) & 32'h3) != 0) m_trap = 1'b1;
    else m_pc = ref_next(m_pc, src, imm);
`else
    m_pc = ref_next(m_pc, src, imm);
`endif
    check("retire_instret", instret, m_instret);
    check("retire_valid", instr_valid, 0);
    check("retire_pc", pc, m_pc);
    check("retire_trap", fetch_trap, m_trap);
    last_issue = issue_cyc; last_wait = ewait; have_last = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, im;
    imem_rvalid = 0; imem_rdata = 0; exec_done = 0; pc_src = 0; imm_ext = 0;
    tbl[0] = '{1, 32'h0050_0093, 7'h13, 0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004, 32'd1};
    tbl[1] = '{1, 32'h0020_8133, 7'h33, 0, 1'b1, 32'h0000_001C, 1'b0, 1'b0, 32'h0000_0020, 32'd2};
    tbl[2] = '{2, 32'h4020_8133, 7'h33, 2, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0000_0010, 32'd3};
    tbl[3] = '{1, 32'h00C5_8663, 7'h63, 0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0014, 32'd4};
    tbl[4] = '{5, 32'h0000_A183, 7'h03, 2, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0018, 32'd5};
    tbl[5] = '{1, 32'h0000_0013, 7'h13, 0, 1'b1, 32'hFFFF_FFE4, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd6};
    tbl[6] = '{1, 32'h0010_0073, 7'h73, 1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 32'd0};

    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    check("idle_req", imem_req, 0);
    @(negedge clk);
    check("req_cycle1", imem_req, 1);
    check("req_cycle1_addr", imem_addr, RESET_PC);
    model_reset();

    for (int k = 0; k < 7; k++) begin
      run_instr(tbl[k].lat, tbl[k].data, tbl[k].op, tbl[k].ewait, tbl[k].src,
                tbl[k].imm, tbl[k].spur, tbl[k].wrap);
      check("tbl_next_pc", pc, tbl[k].next_pc);
      check("tbl_instret", instret, tbl[k].instret);
    end

    for (int k = 0; k < 150; k++) begin
      d  = $urandom;
      im = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      im = im & 32'hFFFF_FFFC;
`endif
      run_instr(int'($urandom_range(1, 4)), d, d[6:0], int'($urandom_range(0, 3)), 1'($urandom),
                im, 1'($urandom), 1'b0);
    end

    // Branch to pc+6
    run_instr(1, 32'h0000_0063, 7'h63, 0, 1'b1, 32'd6, 1'b0, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_set", fetch_trap, 1);
    repeat (10) begin
      imem_rvalid = 1'($urandom); exec_done = 1'($urandom); pc_src = 1'($urandom); imm_ext = $urandom;
      @(negedge clk);
      check("trap_req", imem_req, 0);
      check("trap_hold", fetch_trap, 1);
      check("trap_pc", pc, m_pc);
      check("trap_valid", instr_valid, 0);
      check("trap_instret", instret, m_instret);
    end
    imem_rvalid = 0; exec_done = 0;
`else
    check("trunc_trap", fetch_trap, 0);
    run_instr(1, 32'h0000_0013, 7'h13, 0, 1'b0, 32'd0, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-cycle (clears any trap), no clock edge needed
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst_a");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_instr(1, 32'h0000_0063, 7'h63, 0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_arst_pc", pc, 32'h0000_0040);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_instr(2, 32'h0030_0113, 7'h13, 1, 1'b0, 32'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
